// File: rtl/encode_prefix_stream.sv
// Prefix encoder: turns one instruction request into a byte stream of REP, size prefix, then body.
// Latency: first byte valid the cycle after accept; one byte per cycle while out_ready is high.
// Backpressure: out_ready low freezes byte, last flag and state; in_ready is high only when idle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake; fields are unprefixed_instr, instr_len,
//                         prefix_operand_16bit, prefix_address_16bit, prefix_rep
//   out_byte / out_valid / out_ready / out_last   byte stream to the sink
//   err                   one-cycle pulse after an illegal request is accepted
//   raw_instr, raw_valid  only with ENCODE_PREFIX_RAW_OUT_EN defined: full encoded image,
//                         pulsed alongside the first stream byte
module encode_prefix_stream (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [87:0] unprefixed_instr,
  input  logic [3:0]  instr_len,
  input  logic        prefix_operand_16bit,
  input  logic        prefix_address_16bit,
  input  logic [1:0]  prefix_rep,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        err
`ifdef ENCODE_PREFIX_RAW_OUT_EN
  ,
  output logic [95:0] raw_instr,
  output logic        raw_valid
`endif
);

  typedef enum logic [1:0] {IDLE, PFX, BODY} state_t;

  state_t state_q, state_d;

  logic [95:0] img_q;   // whole encoded instruction, stream byte k at bits [8k+7:8k]
  logic [1:0]  npfx_q;
  logic [3:0]  tot_q;   // npfx + instr_len, at most 12
  logic [3:0]  cnt_q;   // index of the byte currently presented
  logic        err_q;

  logic [1:0]  npfx_w;
  logic [4:0]  tot_w;
  logic        illegal_w;
  logic [7:0]  rep_byte_w;
  logic [7:0]  sz_byte_w;
  logic [15:0] pfx_w;
  logic [87:0] body_mask_w;
  logic [95:0] img_w;
  logic        accept_w;
  logic        legal_accept_w;
  logic        hs_w;
  logic        pfx_last_w;
  logic        body_last_w;

  // Request decode and image assembly: prefixes packed into the low bytes,
  // body bytes beyond instr_len cleared so the image has a clean zero pad.
  always_comb begin
    npfx_w     = {1'b0, prefix_rep != 2'd0} + {1'b0, prefix_operand_16bit}
               + {1'b0, prefix_address_16bit};
    tot_w      = {1'b0, instr_len} + {3'b000, npfx_w};
    illegal_w  = (prefix_rep == 2'd3)
              || (prefix_operand_16bit && prefix_address_16bit)
              || (instr_len == 4'd0)
              || (instr_len > 4'd11)
              || (tot_w > 5'd12);
    rep_byte_w = (prefix_rep == 2'd1) ? 8'hF2 : 8'hF3;
    sz_byte_w  = prefix_operand_16bit ? 8'h66 : 8'h67;
    pfx_w      = 16'h0000;
    if (prefix_rep != 2'd0) begin
      pfx_w[7:0] = rep_byte_w;
      if (prefix_operand_16bit || prefix_address_16bit) pfx_w[15:8] = sz_byte_w;
    end else if (prefix_operand_16bit || prefix_address_16bit) begin
      pfx_w[7:0] = sz_byte_w;
    end
    body_mask_w = '0;
    for (int k = 0; k < 11; k++) begin
      body_mask_w[8*k +: 8] = (4'(k) < instr_len) ? 8'hFF : 8'h00;
    end
    img_w = ({8'h00, unprefixed_instr & body_mask_w} << {npfx_w, 3'b000})
          | {80'h0, pfx_w};
  end

  assign accept_w       = in_valid && in_ready;
  assign legal_accept_w = accept_w && !illegal_w;
  assign hs_w           = out_valid && out_ready;
  assign pfx_last_w     = (cnt_q == ({2'b00, npfx_q} - 4'd1));
  assign body_last_w    = (cnt_q == (tot_q - 4'd1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (legal_accept_w) state_d = (npfx_w != 2'd0) ? PFX : BODY;
      PFX:  if (out_ready && pfx_last_w) state_d = BODY;
      BODY: if (out_ready && body_last_w) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; out_byte is forced to zero while idle so reset shows 8'h00 at once.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q != IDLE);
    out_byte  = out_valid ? img_q[{cnt_q, 3'b000} +: 8] : 8'h00;
    out_last  = (state_q == BODY) && body_last_w;
    err       = err_q;
  end

  // Request capture and byte counter; the counter runs straight through
  // prefixes into body because both live in the same image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_q  <= '0;
      npfx_q <= 2'd0;
      tot_q  <= 4'd0;
      cnt_q  <= 4'd0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept_w && illegal_w;
      if (legal_accept_w) begin
        img_q  <= img_w;
        npfx_q <= npfx_w;
        tot_q  <= tot_w[3:0];
        cnt_q  <= 4'd0;
      end else if (hs_w) begin
        cnt_q <= body_last_w ? 4'd0 : cnt_q + 4'd1;
      end
    end
  end

`ifdef ENCODE_PREFIX_RAW_OUT_EN
  logic raw_valid_q;

  // First stream byte always appears the cycle after a legal accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) raw_valid_q <= 1'b0;
    else        raw_valid_q <= legal_accept_w;
  end

  assign raw_instr = img_q;
  assign raw_valid = raw_valid_q;
`endif

endmodule

// File: tb/tb_encode_prefix_stream.sv
module tb_encode_prefix_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [87:0] unprefixed_instr;
  logic [3:0]  instr_len;
  logic        prefix_operand_16bit;
  logic        prefix_address_16bit;
  logic [1:0]  prefix_rep;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        err;
`ifdef ENCODE_PREFIX_RAW_OUT_EN
  logic [95:0] raw_instr;
  logic        raw_valid;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [7:0] strm [12];
  int         strm_n;

  encode_prefix_stream dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .unprefixed_instr     (unprefixed_instr),
    .instr_len            (instr_len),
    .prefix_operand_16bit (prefix_operand_16bit),
    .prefix_address_16bit (prefix_address_16bit),
    .prefix_rep           (prefix_rep),
    .out_byte             (out_byte),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_last             (out_last),
    .err                  (err)
`ifdef ENCODE_PREFIX_RAW_OUT_EN
    ,
    .raw_instr            (raw_instr),
    .raw_valid            (raw_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [1:0] rep, input logic op, input logic ad,
                      input logic [3:0] len, input logic [87:0] body);
    prefix_rep           = rep;
    prefix_operand_16bit = op;
    prefix_address_16bit = ad;
    instr_len            = len;
    unprefixed_instr     = body;
    in_valid             = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Reference prefix decoder over the captured stream.
  task automatic decode(output int rep, output bit op, output bit ad,
                        output int np);
    rep = 0; op = 0; ad = 0; np = 0;
    for (int i = 0; i < strm_n; i++) begin
      if (strm[i] == 8'hF2)      begin rep = 1; np++; end
      else if (strm[i] == 8'hF3) begin rep = 2; np++; end
      else if (strm[i] == 8'h66) begin op = 1;  np++; end
      else if (strm[i] == 8'h67) begin ad = 1;  np++; end
      else break;
    end
  endtask

  task automatic test_reset();
    #2;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_last !== 1'b0) $display("FAIL rst_out_last got %b exp 0", out_last); else pass_cnt++;
    chk_cnt++; if (err !== 1'b0) $display("FAIL rst_err got %b exp 0", err); else pass_cnt++;
    chk_cnt++; if (out_byte !== 8'h00) $display("FAIL rst_out_byte got %h exp 00", out_byte); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_prefix_stream();
    logic [7:0] exp_b [5];
    logic       exp_l [5];
    int rep, np; bit op, ad;
    exp_b = '{8'hF3, 8'h66, 8'h01, 8'hC3, 8'h90};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    send(2'd2, 1'b1, 1'b0, 4'd3, 88'h90C301);
    chk_cnt++; if (err !== 1'b0) $display("FAIL s1_err got %b exp 0", err); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL s1_busy got %b exp 0", in_ready); else pass_cnt++;
    strm_n = 0;
    for (int i = 0; i < 5; i++) begin
      chk_cnt++; if (out_valid !== 1'b1 || out_byte !== exp_b[i])
        $display("FAIL s1_byte%0d got v=%b %h exp v=1 %h", i, out_valid, out_byte, exp_b[i]); else pass_cnt++;
      chk_cnt++; if (out_last !== exp_l[i])
        $display("FAIL s1_last%0d got %b exp %b", i, out_last, exp_l[i]); else pass_cnt++;
      strm[strm_n] = out_byte; strm_n++;
      @(negedge clk);
    end
    chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL s1_done got v=%b r=%b exp v=0 r=1", out_valid, in_ready); else pass_cnt++;
    decode(rep, op, ad, np);
    chk_cnt++; if (rep != 2 || op != 1'b1 || ad != 1'b0 || np != 2)
      $display("FAIL s1_decode got rep=%0d op=%0b ad=%0b np=%0d exp 2 1 0 2", rep, op, ad, np); else pass_cnt++;
    chk_cnt++; if (strm_n - np != 3 || strm[np] !== 8'h01 || strm[np+1] !== 8'hC3 || strm[np+2] !== 8'h90)
      $display("FAIL s1_decode_body got n=%0d exp 3 bytes 01 C3 90", strm_n - np); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(2'd0, 1'b0, 1'b0, 4'd1, {80'hAABBCCDDEEFF11223344, 8'h90});
    chk_cnt++; if (out_valid !== 1'b1 || out_byte !== 8'h90 || out_last !== 1'b1)
      $display("FAIL s2_byte got v=%b %h l=%b exp v=1 90 l=1", out_valid, out_byte, out_last); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL s2_ready got r=%b v=%b exp r=1 v=0", in_ready, out_valid); else pass_cnt++;
    send(2'd0, 1'b0, 1'b1, 4'd1, 88'h55);
    chk_cnt++; if (out_byte !== 8'h67 || out_last !== 1'b0)
      $display("FAIL b2b_pfx got %h l=%b exp 67 l=0", out_byte, out_last); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (out_byte !== 8'h55 || out_last !== 1'b1)
      $display("FAIL b2b_body got %h l=%b exp 55 l=1", out_byte, out_last); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic       rdy   [5];
    logic [7:0] exp_b [5];
    logic       exp_l [5];
    rdy   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_b = '{8'h67, 8'h8B, 8'h8B, 8'h8B, 8'h00};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    send(2'd0, 1'b0, 1'b1, 4'd2, 88'h008B);
    for (int i = 0; i < 5; i++) begin
      out_ready = rdy[i];
      chk_cnt++; if (out_valid !== 1'b1 || out_byte !== exp_b[i] || out_last !== exp_l[i])
        $display("FAIL s3_cyc%0d got v=%b %h l=%b exp v=1 %h l=%b", i, out_valid, out_byte, out_last, exp_b[i], exp_l[i]);
      else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL s3_done got v=%b r=%b exp v=0 r=1", out_valid, in_ready); else pass_cnt++;
  endtask

  task automatic test_illegal();
    logic [1:0] reps [5];
    logic       ops  [5];
    logic       ads  [5];
    logic [3:0] lens [5];
    reps = '{2'd0, 2'd3, 2'd1, 2'd0, 2'd0};
    ops  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    ads  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    lens = '{4'd2, 4'd2, 4'd11, 4'd0, 4'd12};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(reps[i], ops[i], ads[i], lens[i], 88'h0102030405060708090A0B);
      chk_cnt++; if (err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL s4_err%0d got e=%b v=%b r=%b exp e=1 v=0 r=1", i, err, out_valid, in_ready); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (err !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL s4_after%0d got e=%b v=%b exp e=0 v=0", i, err, out_valid); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b1;
    send(2'd1, 1'b1, 1'b0, 4'd3, 88'h030201);
    chk_cnt++; if (out_byte !== 8'hF2) $display("FAIL s5_b0 got %h exp F2", out_byte); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (out_byte !== 8'h66) $display("FAIL s5_b1 got %h exp 66", out_byte); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_byte !== 8'h00 || out_last !== 1'b0)
      $display("FAIL s5_rst got v=%b r=%b %h l=%b exp v=0 r=1 00 l=0", out_valid, in_ready, out_byte, out_last);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (err !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL s5_rst_hold got e=%b v=%b exp e=0 v=0", err, out_valid); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    send(2'd0, 1'b0, 1'b0, 4'd2, 88'h2211);
    chk_cnt++; if (out_byte !== 8'h11 || out_last !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL s5_new0 got %h l=%b v=%b exp 11 l=0 v=1", out_byte, out_last, out_valid); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (out_byte !== 8'h22 || out_last !== 1'b1)
      $display("FAIL s5_new1 got %h l=%b exp 22 l=1", out_byte, out_last); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_raw_image();
    logic [7:0] exp_b [4];
    int rep, np; bit op, ad;
    exp_b = '{8'hF2, 8'h66, 8'h01, 8'hD8};
    out_ready = 1'b1;
    send(2'd1, 1'b1, 1'b0, 4'd2, {72'hEEEEEEEEEEEEEEEEEE, 16'hD801});
`ifdef ENCODE_PREFIX_RAW_OUT_EN
    chk_cnt++; if (raw_valid !== 1'b1 || raw_instr !== 96'h0000_0000_0000_0000_D801_66F2)
      $display("FAIL s6_raw got v=%b %h exp v=1 0000000000000000D80166F2", raw_valid, raw_instr); else pass_cnt++;
`endif
    strm_n = 0;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++; if (out_valid !== 1'b1 || out_byte !== exp_b[i])
        $display("FAIL s6_byte%0d got v=%b %h exp v=1 %h", i, out_valid, out_byte, exp_b[i]); else pass_cnt++;
      strm[strm_n] = out_byte; strm_n++;
      @(negedge clk);
`ifdef ENCODE_PREFIX_RAW_OUT_EN
      if (i == 0) begin
        chk_cnt++; if (raw_valid !== 1'b0) $display("FAIL s6_raw_pulse got %b exp 0", raw_valid); else pass_cnt++;
      end
`endif
    end
    decode(rep, op, ad, np);
    chk_cnt++; if (rep != 1 || op != 1'b1 || ad != 1'b0 || np != 2)
      $display("FAIL s6_decode got rep=%0d op=%0b ad=%0b np=%0d exp 1 1 0 2", rep, op, ad, np); else pass_cnt++;
    chk_cnt++; if (strm_n - np != 2 || strm[np] !== 8'h01 || strm[np+1] !== 8'hD8)
      $display("FAIL s6_decode_body got n=%0d exp 2 bytes 01 D8", strm_n - np); else pass_cnt++;
  endtask

  initial begin
    rst_n                = 1'b0;
    in_valid             = 1'b0;
    unprefixed_instr     = '0;
    instr_len            = 4'd0;
    prefix_operand_16bit = 1'b0;
    prefix_address_16bit = 1'b0;
    prefix_rep           = 2'd0;
    out_ready            = 1'b1;
    test_reset();
    test_prefix_stream();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_mid_stream();
    test_raw_image();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/encode_prefix_stream.md
ENCODE_PREFIX_STREAM -- requirements
Module: encode_prefix_stream

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), with the clock and reset listed first:
  clk  in  1  single clock; all state changes on the rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  in_valid  in  1  request present.
  in_ready  out  1  block can accept a request; equals (state==IDLE).
  unprefixed_instr  in  88  instruction body, byte k = bits [8k+7:8k].
  instr_len  in  4  number of body bytes, 1..11.
  prefix_operand_16bit  in  1  emit 8'h66.
  prefix_address_16bit  in  1  emit 8'h67.
  prefix_rep  in  2  0=none, 1=emit 8'hF2, 2=emit 8'hF3, 3=illegal.
  out_byte  out  8  current stream byte.
  out_valid  out  1  out_byte valid.
  out_ready  in  1  sink accepts the byte.
  out_last  out  1  final byte of the instruction.
  err  out  1  one-cycle pulse: request rejected.

Function
REQ-002 A request SHALL be accepted on any rising edge where in_valid && in_ready; the block SHALL register all request fields at that edge.
REQ-003 The FSM SHALL have three states, IDLE, PFX and BODY, with these transitions:
  IDLE to PFX on a legal accept with npfx>0.
  IDLE to BODY on a legal accept with npfx==0.
  PFX to BODY after the last prefix byte handshakes.
  BODY to IDLE after the last body byte handshakes.
REQ-004 npfx SHALL equal (prefix_rep!=0) + prefix_operand_16bit + prefix_address_16bit.
REQ-005 The emission order SHALL be canonical: the REP byte (F2/F3) first, then 66 or 67, then body bytes 0..instr_len-1 in ascending order.
REQ-006 A request SHALL be illegal if any of the following holds:
  prefix_rep==3.
  prefix_operand_16bit && prefix_address_16bit are both set.
  instr_len==0.
  instr_len>11.
  npfx+instr_len>12.
REQ-007 For an illegal request, the block SHALL still accept it, pulse err for exactly the cycle after the accept edge, emit no bytes, and remain in IDLE.
REQ-008 out_valid SHALL be high in PFX and BODY, and low in IDLE.
REQ-009 The first byte of a legal request SHALL be valid in the cycle after the accept edge (latency 1).
REQ-010 The block SHALL advance one byte per cycle when out_valid && out_ready (throughput 1 byte/clk).
REQ-011 While out_valid && !out_ready, out_byte, out_last and the state SHALL hold stable.
REQ-012 out_last SHALL be high only while the final body byte is presented.
REQ-013 The block SHALL have no back-to-back overlap: in_ready rises in the cycle after the out_last handshake, so a single instruction occupies npfx+instr_len+1 cycles minimum.
REQ-014 The internal byte counter SHALL be 4 bits and SHALL never wrap, because the legal range caps the count at 12.
REQ-015 Every legal output stream SHALL be recovered unchanged by the team's prefix decoder: the same body bytes, the same flags, and a prefix count equal to npfx.

Reset
REQ-016 Asserting rst_n low SHALL immediately force the following state:
  state=IDLE, out_valid=0, out_last=0, err=0, out_byte=8'h00.
  in_ready=1.
  All counters 0.
REQ-017 When reset is asserted mid-stream, the block SHALL abandon the instruction with no completion or err signalled; the first post-reset request SHALL start a fresh stream.

Configuration
REQ-018 The macro ENCODE_PREFIX_RAW_OUT_EN SHALL control an optional raw-image output.
  Defined: the block adds outputs raw_instr[95:0] and raw_valid.
  raw_instr SHALL be registered at a legal accept as {zero pad, body, prefixes}, with the byte layout from REQ-005, LSB byte first, and unused upper bytes 0.
  raw_valid SHALL pulse for one cycle, coincident with the first out_valid cycle.
  Both outputs SHALL reset to 0.
  Undefined: neither port exists, and the stream behaviour is identical.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  Scenario 1: rep=2, op16=1, len=3, body bytes 01 C3 90, out_ready=1 -> bytes F3,66,01,C3,90 on 5 consecutive cycles starting 1 cycle after accept; out_last only on 90.
  Scenario 2: no prefixes, len=1, body 90 -> single byte 90 with out_last=1; in_ready high again the next cycle.
  Scenario 3: addr16=1, len=2, body 8B 00, out_ready toggling 1,0,0,1,1 -> bytes 67,8B,00 each held stable through stalls; no byte lost or duplicated.
  Scenario 4: op16=1 and addr16=1 together (also rep=3; and rep=1, op16=1, len=11) -> err pulses 1 cycle per request, out_valid never asserts.
  Scenario 5: rst_n driven low while the 2nd byte of a 5-byte stream is presented -> out_valid=0 and in_ready=1 immediately; the next request streams correctly.
  Scenario 6: with ENCODE_PREFIX_RAW_OUT_EN, rep=1, op16=1, len=2, body 01 D8 -> raw_instr = 96'h...00_D801_66F2 (bytes F2,66,01,D8 from LSB, rest 0); the raw image fed through the decoder yields rep=1, op16=1, prefix count 2, body bytes 01 D8.
